// File: rtl/spi_flash_sequencer.sv
// rtl/spi_flash_sequencer.sv - APB master sequencing SPI-flash READ (0x03) frames
// One byte in flight at a time: TXDATA write, then RXDATA polls until a byte arrives.
module spi_flash_sequencer #(
  parameter logic [7:0] CMD_READ   = 8'h03,
  parameter int         POLL_LIMIT = 1024
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [23:0] ReqAddr,
  input  logic [2:0]  ReqLen,
  input  logic [1:0]  ReqCsId,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [63:0] RspData,
  output logic        RspErr,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam int               PollW    = $clog2(POLL_LIMIT + 1);
  localparam logic [PollW-1:0] PollMax  = PollW'(POLL_LIMIT);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_LIMIT - 1);

  localparam logic [7:0] AddrCsId   = 8'h10;
  localparam logic [7:0] AddrCsMode = 8'h18;
  localparam logic [7:0] AddrTxData = 8'h48;
  localparam logic [7:0] AddrRxData = 8'h4C;

  typedef enum logic [2:0] {
    IDLE,
    SETID,
    HOLD,
    TX,
    RX,
    REL,
    RESP
  } state_t;

  state_t           state;
  logic [23:0]      addr;
  logic [2:0]       len;
  logic [1:0]       csId;
  logic [3:0]       byteIdx;
  logic [PollW-1:0] pollCnt;

  logic [7:0]  txByte;
  logic [3:0]  lastIdx;
  logic [2:0]  rxSlot;
  logic        xferDone;
  logic        xActive;
  logic        xWrite;
  logic [7:0]  xAddr;
  logic [31:0] xWdata;
  logic        unusedPrdata;

  assign lastIdx      = {1'b0, len} + 4'd4;
  assign rxSlot       = 3'(byteIdx - 4'd4);
  assign xferDone     = PSEL & PENABLE & PREADY;
  assign unusedPrdata = ^PRDATA[30:8];

  always_comb begin
    case (byteIdx)
      4'd0:    txByte = CMD_READ;
      4'd1:    txByte = addr[23:16];
      4'd2:    txByte = addr[15:8];
      4'd3:    txByte = addr[7:0];
      default: txByte = 8'h00;
    endcase
  end

  // Transfer the current state wants on the bus; launched whenever PSEL is low.
  always_comb begin
    xActive = 1'b0;
    xWrite  = 1'b0;
    xAddr   = 8'h00;
    xWdata  = 32'h0;
    case (state)
      SETID: begin xActive = 1'b1; xWrite = 1'b1; xAddr = AddrCsId;   xWdata = {30'b0, csId}; end
      HOLD:  begin xActive = 1'b1; xWrite = 1'b1; xAddr = AddrCsMode; xWdata = 32'd2; end
      TX:    begin xActive = 1'b1; xWrite = 1'b1; xAddr = AddrTxData; xWdata = {24'b0, txByte}; end
      RX:    begin xActive = 1'b1; xWrite = 1'b0; xAddr = AddrRxData; xWdata = 32'h0; end
      REL:   begin xActive = 1'b1; xWrite = 1'b1; xAddr = AddrCsMode; xWdata = 32'h0; end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      ReqReady <= 1'b1;
      RspValid <= 1'b0;
      RspErr   <= 1'b0;
      RspData  <= 64'h0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= 8'h00;
      PWDATA   <= 32'h0;
      addr     <= 24'h0;
      len      <= 3'd0;
      csId     <= 2'd0;
      byteIdx  <= 4'd0;
      pollCnt  <= '0;
    end else begin
      // The completion cycle drops PSEL, which guarantees an idle gap before the next SETUP.
      if (xActive && !PSEL) begin
        PSEL   <= 1'b1;
        PWRITE <= xWrite;
        PADDR  <= xAddr;
        PWDATA <= xWdata;
      end else if (PSEL && !PENABLE) begin
        PENABLE <= 1'b1;
      end else if (xferDone) begin
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ReqValid) begin
            addr     <= ReqAddr;
            len      <= ReqLen;
            csId     <= ReqCsId;
            byteIdx  <= 4'd0;
            ReqReady <= 1'b0;
            state    <= SETID;
          end
        end
        SETID: if (xferDone) state <= HOLD;
        HOLD:  if (xferDone) state <= TX;
        TX: begin
          if (xferDone) begin
            pollCnt <= '0;
            state   <= RX;
          end
        end
        RX: begin
          if (xferDone) begin
            if (PRDATA[31]) begin
              if (pollCnt != PollMax) pollCnt <= pollCnt + 1'b1;
              if (pollCnt >= PollLast) begin
                RspErr <= 1'b1;
                state  <= REL;
              end
            end else begin
              // Header-phase bytes are drained but not kept, keeping the RX FIFO aligned.
              if (byteIdx >= 4'd4) RspData[{rxSlot, 3'b000} +: 8] <= PRDATA[7:0];
              if (byteIdx == lastIdx) begin
                state <= REL;
              end else begin
                byteIdx <= byteIdx + 4'd1;
                state   <= TX;
              end
            end
          end
        end
        REL: begin
          if (xferDone) begin
            RspValid <= 1'b1;
            state    <= RESP;
          end
        end
        RESP: begin
          if (RspReady) begin
            RspValid <= 1'b0;
            RspData  <= 64'h0;
            RspErr   <= 1'b0;
            ReqReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// tb/tb_spi_flash_sequencer.sv - bench for spi_flash_sequencer with an SPI peripheral model
module tb_spi_flash_sequencer;
  localparam int TmoLimit = 4;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  int compared = 0;
  int mismatched = 0;

  logic        reqValid = 1'b0;
  logic        useT = 1'b0;
  logic [23:0] reqAddr = 24'h0;
  logic [2:0]  reqLen = 3'd0;
  logic [1:0]  reqCsId = 2'd0;
  logic        rspReady = 1'b0;
  logic [31:0] PRDATA = 32'h0;
  logic        PREADY = 1'b0;

  logic        mReqReady, mRspValid, mRspErr, mPsel, mPenable, mPwrite;
  logic [63:0] mRspData;
  logic [7:0]  mPaddr;
  logic [31:0] mPwdata;
  logic        tReqReady, tRspValid, tRspErr, tPsel, tPenable, tPwrite;
  logic [63:0] tRspData;
  logic [7:0]  tPaddr;
  logic [31:0] tPwdata;

  logic        psel, penable, pwrite, reqReady, rspValid, rspErr;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [63:0] rspData;

  assign psel     = useT ? tPsel     : mPsel;
  assign penable  = useT ? tPenable  : mPenable;
  assign pwrite   = useT ? tPwrite   : mPwrite;
  assign paddr    = useT ? tPaddr    : mPaddr;
  assign pwdata   = useT ? tPwdata   : mPwdata;
  assign reqReady = useT ? tReqReady : mReqReady;
  assign rspValid = useT ? tRspValid : mRspValid;
  assign rspErr   = useT ? tRspErr   : mRspErr;
  assign rspData  = useT ? tRspData  : mRspData;

  spi_flash_sequencer dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .ReqValid(reqValid & ~useT), .ReqReady(mReqReady),
    .ReqAddr(reqAddr), .ReqLen(reqLen), .ReqCsId(reqCsId),
    .RspValid(mRspValid), .RspReady(rspReady), .RspData(mRspData), .RspErr(mRspErr),
    .PSEL(mPsel), .PENABLE(mPenable), .PWRITE(mPwrite),
    .PADDR(mPaddr), .PWDATA(mPwdata), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  spi_flash_sequencer #(.POLL_LIMIT(TmoLimit)) dutTmo (
    .PCLK(PCLK), .PRESET(PRESET),
    .ReqValid(reqValid & useT), .ReqReady(tReqReady),
    .ReqAddr(reqAddr), .ReqLen(reqLen), .ReqCsId(reqCsId),
    .RspValid(tRspValid), .RspReady(rspReady), .RspData(tRspData), .RspErr(tRspErr),
    .PSEL(tPsel), .PENABLE(tPenable), .PWRITE(tPwrite),
    .PADDR(tPaddr), .PWDATA(tPwdata), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI peripheral model: each TXDATA write clocks one flash byte into rxFifo.
  int          waitCycles, emptyPerByte, emptiesLeft, waitLeft;
  bit          alwaysEmpty, doneLast;
  logic [7:0]  rxFifo[$];
  logic [7:0]  pendingRx[$];
  logic [40:0] apbLog[$];
  logic [7:0]  sAddr;
  logic        sWr;
  logic [31:0] sData;

  function automatic logic [31:0] rdResp();
    if (alwaysEmpty || emptiesLeft > 0 || rxFifo.size() == 0) begin
      if (emptiesLeft > 0) emptiesLeft--;
      return {1'b1, 31'($urandom)};
    end
    return {1'b0, 23'($urandom), rxFifo.pop_front()};
  endfunction

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rxFifo.delete();
      PREADY   <= 1'b0;
      PRDATA   <= 32'h0;
      doneLast = 1'b0;
    end else begin
      if (doneLast) check("psel gap", 64'(psel), 64'(0));
      doneLast = 1'b0;
      if (psel && !penable) begin
        sAddr    = paddr;
        sWr      = pwrite;
        sData    = pwdata;
        waitLeft = waitCycles;
        if (waitLeft == 0) begin
          PREADY <= 1'b1;
          PRDATA <= sWr ? $urandom : rdResp();
        end
      end else if (psel && penable) begin
        check("paddr stable", 64'(paddr), 64'(sAddr));
        check("pwrite stable", 64'(pwrite), 64'(sWr));
        if (sWr) check("pwdata stable", 64'(pwdata), 64'(sData));
        if (PREADY) begin
          apbLog.push_back({pwrite, paddr, pwrite ? pwdata : 32'h0});
          if (pwrite && paddr == 8'h48) begin
            rxFifo.push_back(pendingRx.size() != 0 ? pendingRx.pop_front() : 8'hEE);
            emptiesLeft = emptyPerByte;
          end
          PREADY   <= 1'b0;
          doneLast = 1'b1;
        end else begin
          waitLeft--;
          if (waitLeft <= 0) begin
            PREADY <= 1'b1;
            PRDATA <= sWr ? $urandom : rdResp();
          end
        end
      end
    end
  end

  function automatic logic [7:0] txByteOf(input logic [23:0] a, input int i);
    case (i)
      0:       return 8'h03;
      1:       return a[23:16];
      2:       return a[15:8];
      3:       return a[7:0];
      default: return 8'h00;
    endcase
  endfunction

  task automatic runTxn(input logic [23:0] a, input logic [2:0] l, input logic [1:0] cs,
                        input int waits, input int empties, input logic [63:0] data,
                        input bit tmo, input string tag);
    logic [63:0] expData;
    logic [40:0] expLog[$];
    int n;
    int m;
    bit seen;
    n = int'(l) + 1;
    waitCycles = waits;
    emptyPerByte = empties;
    alwaysEmpty = tmo;
    emptiesLeft = 0;
    pendingRx.delete();
    rxFifo.delete();
    apbLog.delete();
    expData = 64'h0;
    repeat (4) pendingRx.push_back(8'($urandom));
    for (int k = 0; k < n; k++) begin
      pendingRx.push_back(data[8*k +: 8]);
      if (!tmo) expData[8*k +: 8] = data[8*k +: 8];
    end
    expLog.push_back({1'b1, 8'h10, 30'h0, cs});
    expLog.push_back({1'b1, 8'h18, 32'd2});
    for (int i = 0; i < (tmo ? 1 : n + 4); i++) begin
      expLog.push_back({1'b1, 8'h48, 24'h0, txByteOf(a, i)});
      repeat (tmo ? TmoLimit : empties + 1) expLog.push_back({1'b0, 8'h4C, 32'h0});
    end
    expLog.push_back({1'b1, 8'h18, 32'h0});

    useT = tmo;
    reqAddr = a;
    reqLen = l;
    reqCsId = cs;
    reqValid = 1'b1;
    @(negedge PCLK);
    reqValid = 1'b0;
    check({tag, " busy ready"}, 64'(reqReady), 64'(0));
    repeat (3) @(negedge PCLK);
    reqAddr = ~a;
    reqValid = 1'b1;
    @(negedge PCLK);
    reqValid = 1'b0;

    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (rspValid) seen = 1'b1;
      else @(negedge PCLK);
    end
    check({tag, " rsp arrived"}, 64'(seen), 64'(1));
    check({tag, " rsp data"}, rspData, expData);
    check({tag, " rsp err"}, 64'(rspErr), 64'(tmo));
    repeat (3) @(negedge PCLK);
    check({tag, " rsp held"}, 64'(rspValid), 64'(1));
    check({tag, " data held"}, rspData, expData);
    rspReady = 1'b1;
    @(negedge PCLK);
    rspReady = 1'b0;
    check({tag, " rsp dropped"}, 64'(rspValid), 64'(0));
    check({tag, " data cleared"}, rspData, 64'h0);
    check({tag, " err cleared"}, 64'(rspErr), 64'(0));
    check({tag, " ready again"}, 64'(reqReady), 64'(1));

    check({tag, " apb count"}, 64'(apbLog.size()), 64'(expLog.size()));
    m = apbLog.size() < expLog.size() ? apbLog.size() : expLog.size();
    for (int i = 0; i < m; i++) check({tag, " apb xfer"}, 64'(apbLog[i]), 64'(expLog[i]));
    repeat (3) @(negedge PCLK);
    check({tag, " no queued req"}, 64'(psel), 64'(0));
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge PCLK);
    check("reset req ready", 64'(reqReady), 64'(1));
    check("reset rsp valid", 64'(rspValid), 64'(0));
    check("reset rsp err", 64'(rspErr), 64'(0));
    check("reset rsp data", rspData, 64'h0);
    check("reset psel", 64'(psel), 64'(0));
    check("reset penable", 64'(penable), 64'(0));
    check("reset pwrite", 64'(pwrite), 64'(0));
    check("reset paddr", 64'(paddr), 64'(0));
    check("reset pwdata", 64'(pwdata), 64'(0));
    PRESET = 1'b0;
    @(negedge PCLK);

    runTxn(24'h012345, 3'd0, 2'd1, 0, 0, 64'hA5, 1'b0, "single");
    runTxn(24'($urandom), 3'd7, 2'd2, 0, 0, 64'h8877665544332211, 1'b0, "eight");
    runTxn(24'hABCDEF, 3'd7, 2'd3, 3, 0, 64'h8877665544332211, 1'b0, "waits");
    runTxn(24'($urandom), 3'd2, 2'd0, 0, 5, {$urandom, $urandom}, 1'b0, "empties");
    runTxn(24'($urandom), 3'd3, 2'd1, 1, 0, {$urandom, $urandom}, 1'b1, "timeout");
    for (int r = 0; r < 6; r++)
      runTxn(24'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), {$urandom, $urandom}, 1'b0, "random");

    useT = 1'b0;
    waitCycles = 0;
    emptyPerByte = 2;
    alwaysEmpty = 1'b0;
    reqAddr = 24'h55AA55;
    reqLen = 3'd1;
    reqCsId = 2'd2;
    reqValid = 1'b1;
    @(negedge PCLK);
    reqValid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (psel && paddr == 8'h4C) seen = 1'b1;
      else @(negedge PCLK);
    end
    check("midrx reached", 64'(seen), 64'(1));
    #2 PRESET = 1'b1;
    #1;
    check("midrx psel", 64'(psel), 64'(0));
    check("midrx penable", 64'(penable), 64'(0));
    check("midrx pwrite", 64'(pwrite), 64'(0));
    check("midrx paddr", 64'(paddr), 64'(0));
    check("midrx pwdata", 64'(pwdata), 64'(0));
    check("midrx rsp valid", 64'(rspValid), 64'(0));
    check("midrx rsp data", rspData, 64'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("post reset ready", 64'(reqReady), 64'(1));
    check("post reset psel", 64'(psel), 64'(0));

    runTxn(24'($urandom), 3'd4, 2'd3, 2, 1, {$urandom, $urandom}, 1'b0, "recovery");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_flash_sequencer.md
Name: spi_flash_sequencer

Overview:
- APB master that sequences the SPI peripheral's register interface to perform SPI-flash READ (0x03) transactions for a single requester (boot loader / XIP fetch path).
- Accepts a 24-bit byte address and length (1–8 bytes) and selects the chip select.
- Holds CS across the frame, shifts out command, address and dummy bytes, and drains the receive FIFO byte-by-byte.
- Returns the data bytes packed little-endian.

Parameters:
- CMD_READ, 8'h03, flash read opcode sent as first byte.
- POLL_LIMIT, 1024, max consecutive RXDATA reads returning empty before a byte is declared lost.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous, active-high reset.
- ReqValid  in  1  request valid.
- ReqReady  out  1  sequencer idle, request accepted when ReqValid & ReqReady.
- ReqAddr  in  24  flash byte address.
- ReqLen  in  3  byte count minus 1 (0 = 1 byte, 7 = 8 bytes).
- ReqCsId  in  2  chip select ID to program.
- RspValid  out  1  response valid.
- RspReady  in  1  response consumed.
- RspData  out  64  read bytes; byte k at [8k+7:8k]; unused bytes zero.
- RspErr  out  1  poll timeout occurred.
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
- PADDR  out  8  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset values: ReqReady=1; RspValid=0, RspErr=0, RspData=0; PSEL=0, PENABLE=0, PWRITE=0; PADDR=0, PWDATA=0; state IDLE.
- Reset mid-transaction aborts immediately with no APB cleanup; the SPI peripheral shares this reset.
- Request capture: ReqAddr/ReqLen/ReqCsId latched on acceptance; ReqReady=1 only in IDLE.
- Frame: byte index i runs 0..N+3, where N = ReqLen+1.
  - Tx byte i: 0 → CMD_READ; 1, 2, 3 → ReqAddr[23:16], [15:8], [7:0]; ≥4 → 8'h00.
- Every APB transfer is one SETUP cycle (PSEL=1, PENABLE=0), then ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1.
  - PADDR/PWRITE/PWDATA are stable from SETUP through completion.
  - PSEL drops for at least one cycle between transfers.
- States:
  - IDLE: on accept → SETID.
  - SETID: write PADDR 0x10, PWDATA {30'b0, ReqCsId} → HOLD.
  - HOLD: write 0x18, PWDATA 2 (CS hold) → TX.
  - TX: write 0x48, PWDATA {24'b0, txbyte(i)}, then clear the poll counter → RX.
  - RX: read 0x4C.
    - If PRDATA[31]=1 (empty): increment poll counter; if it reaches POLL_LIMIT, set RspErr → REL; else repeat RX.
    - If PRDATA[31]=0: if i≥4, store PRDATA[7:0] to RspData byte i-4. Then if i=N+3 → REL; else i++ → TX.
  - REL: write 0x18, PWDATA 0 (CS auto), issued on both normal completion and timeout → RESP.
  - RESP: RspValid=1, holding RspData/RspErr until RspValid & RspReady → IDLE, clearing RspData/RspErr on exit.
- One byte is in flight at a time, so the 8-deep TX/RX FIFOs never fill; TXDATA full flag is not checked.
- Minimum transaction with PREADY=1 and data on first poll: 2 + 2 + (N+4)·4 + 2 cycles of APB activity, plus 1 cycle RESP.
- Bytes received before index 4 are discarded but still read, keeping the RX FIFO aligned.
- Poll counter width is clog2(POLL_LIMIT+1); it saturates and never wraps.
- ReqValid while busy is ignored (not queued).

Test Plan:
- Reset: assert PRESET asynchronously mid-RX → outputs return to reset values within the same cycle; ReqReady=1 next cycle.
- Single byte: ReqAddr=24'h012345, ReqLen=0, ReqCsId=1, SPI model echoes 8'hA5 as 5th rx byte → APB write sequence 0x10←1, 0x18←2, then TXDATA 03,01,23,45,00, then 0x18←0; RspData=64'hA5, RspErr=0.
- Eight bytes: ReqLen=7, flash returns 11..88 → RspData=64'h8877665544332211, 12 TXDATA writes, exactly one non-empty RX read per write.
- Wait states: PREADY low 3 cycles on every transfer → identical APB write/read sequence and data; PADDR/PWDATA stable across the wait states.
- Empty polls: RXDATA returns bit31=1 five times before data → five extra RX reads, correct data, no error.
- Timeout: POLL_LIMIT=4, RXDATA always empty → exactly 4 reads, then CSMODE←0 write; RspErr=1, RspValid held until RspReady.
